// File: rtl/io_input_port_pkg.sv
// ============================================================================
// io_input_port_pkg : register width, I/O address map and read-select decode
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_input_port_pkg;

    localparam int REG_WIDTH = 16;
    localparam int NUM_SW    = 10;
    localparam int NUM_KEYS  = 4;

    localparam logic [REG_WIDTH-1:0] ADDR_IO_SW      = 16'hFFF0;
    localparam logic [REG_WIDTH-1:0] ADDR_IO_KEY     = 16'hFFF1;
    localparam logic [REG_WIDTH-1:0] ADDR_IO_KEYEDGE = 16'hFFF2;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'd0,
        SEL_SW      = 2'd1,
        SEL_KEY     = 2'd2,
        SEL_KEYEDGE = 2'd3
    } rd_sel_e;

    function automatic rd_sel_e decode_addr(input logic [REG_WIDTH-1:0] addr);
        rd_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_IO_SW)           sel = SEL_SW;
        else if (addr == ADDR_IO_KEY)     sel = SEL_KEY;
        else if (addr == ADDR_IO_KEYEDGE) sel = SEL_KEYEDGE;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_input_port_key_debounce.sv
// ============================================================================
// key_debounce : per-key stability filter with a one-cycle press (rise) pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [15:0] c_last_count = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        level_q;
    logic        level_d;

    // The counter only runs while the input disagrees, and is cleared on
    // acceptance, so it can never overflow.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_o  = 1'b0;
        if (level_i == level_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q == c_last_count) begin
            level_d = level_i;
            cnt_d   = 16'd0;
            rise_o  = level_i;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 16'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/io_input_port.sv
// ============================================================================
// io_input_port : memory-mapped switch/key input port, one-cycle read latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_input_port
    import io_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic [NUM_SW-1:0]    I_SW,
    input  logic [NUM_KEYS-1:0]  I_KEY,
    input  logic                 I_ReadEnable,
    input  logic [REG_WIDTH-1:0] I_ReadAddr,
    output logic                 O_ReadValid,
    output logic                 O_ReadHit,
    output logic [REG_WIDTH-1:0] O_ReadData,
    output logic                 O_KeyEvent
);

    logic [SYNC_STAGES-1:0][NUM_SW-1:0]   sw_pipe_q;
    logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] key_pipe_q;
    logic [NUM_SW-1:0]                    sw_sync;
    logic [NUM_KEYS-1:0]                  key_pressed;
    logic [NUM_KEYS-1:0]                  key_db;
    logic [NUM_KEYS-1:0]                  key_rise;

    logic [NUM_KEYS-1:0]  edge_q;
    logic [NUM_KEYS-1:0]  edge_d;
    logic [NUM_KEYS-1:0]  edge_clr;
    logic                 key_event_q;
    logic                 valid_q;
    logic                 hit_q;
    logic [REG_WIDTH-1:0] data_q;

    rd_sel_e              rd_sel;
    logic [REG_WIDTH-1:0] rd_data;

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            sw_pipe_q  <= '0;
            key_pipe_q <= {SYNC_STAGES{{NUM_KEYS{1'b1}}}};
        end else begin
            sw_pipe_q  <= {sw_pipe_q[SYNC_STAGES-2:0], I_SW};
            key_pipe_q <= {key_pipe_q[SYNC_STAGES-2:0], I_KEY};
        end
    end

    assign sw_sync     = sw_pipe_q[SYNC_STAGES-1];
    assign key_pressed = ~key_pipe_q[SYNC_STAGES-1];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk_i   (I_CLOCK),
            .rst_ni  (I_RESET_N),
            .level_i (key_pressed[k]),
            .level_o (key_db[k]),
            .rise_o  (key_rise[k])
        );
    end

    // Read returns pre-clear EDGE; only returned bits clear, and a same-cycle
    // rise re-sets its bit so no press is ever lost.
    always_comb begin
        rd_sel   = decode_addr(I_ReadAddr);
        rd_data  = '0;
        edge_clr = '0;
        case (rd_sel)
            SEL_SW:      rd_data = {{(REG_WIDTH-NUM_SW){1'b0}}, sw_sync};
            SEL_KEY:     rd_data = {{(REG_WIDTH-NUM_KEYS){1'b0}}, key_db};
            SEL_KEYEDGE: rd_data = {{(REG_WIDTH-NUM_KEYS){1'b0}}, edge_q};
            default:     rd_data = '0;
        endcase
        if (I_ReadEnable && (rd_sel == SEL_KEYEDGE)) begin
            edge_clr = edge_q;
        end
        edge_d = (edge_q & ~edge_clr) | key_rise;
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            edge_q      <= '0;
            key_event_q <= 1'b0;
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            edge_q      <= edge_d;
            key_event_q <= |edge_d;
            valid_q     <= I_ReadEnable;
            if (I_ReadEnable) begin
                hit_q  <= (rd_sel != SEL_NONE);
                data_q <= rd_data;
            end
        end
    end

    assign O_ReadValid = valid_q;
    assign O_ReadHit   = hit_q;
    assign O_ReadData  = data_q;
    assign O_KeyEvent  = key_event_q;

endmodule

`default_nettype wire

// File: tb/tb_io_input_port.sv
// ============================================================================
// tb_io_input_port : scoreboard + vector-table bench for io_input_port
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_input_port;

    logic        clk;
    logic        rst_n;
    logic [9:0]  I_SW;
    logic [3:0]  I_KEY;
    logic        I_ReadEnable;
    logic [15:0] I_ReadAddr;
    logic        O_ReadValid;
    logic        O_ReadHit;
    logic [15:0] O_ReadData;
    logic        O_KeyEvent;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic [9:0]  sw;
        logic [15:0] addr;
        logic        hit;
        logic [15:0] data;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    io_input_port #(
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2)
    ) dut (
        .I_CLOCK      (clk),
        .I_RESET_N    (rst_n),
        .I_SW         (I_SW),
        .I_KEY        (I_KEY),
        .I_ReadEnable (I_ReadEnable),
        .I_ReadAddr   (I_ReadAddr),
        .O_ReadValid  (O_ReadValid),
        .O_ReadHit    (O_ReadHit),
        .O_ReadData   (O_ReadData),
        .O_KeyEvent   (O_KeyEvent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Output monitor: every valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (O_ReadValid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_valid: got valid=1 expected no outstanding read");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_hit"}, {31'd0, O_ReadHit}, {31'd0, e.hit});
                chk({e.name, "_data"}, {16'd0, O_ReadData}, {16'd0, e.data});
            end
        end
    end

    task automatic drain_check(input string nm);
        @(posedge clk);
        #1;
        chk({nm, "_latency"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic rd(input string nm, input logic [15:0] a, input logic h, input logic [15:0] d);
        @(negedge clk);
        I_ReadEnable = 1'b1;
        I_ReadAddr   = a;
        sb_q.push_back('{nm, h, d});
        @(negedge clk);
        I_ReadEnable = 1'b0;
        drain_check(nm);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"sw_2a5",   10'h2A5, 16'hFFF0, 1'b1, 16'h02A5};
        vecs[1] = '{"sw_3ff",   10'h3FF, 16'hFFF0, 1'b1, 16'h03FF};
        vecs[2] = '{"miss_1234",10'h155, 16'h1234, 1'b0, 16'h0000};
        vecs[3] = '{"key_idle", 10'h155, 16'hFFF1, 1'b1, 16'h0000};
        vecs[4] = '{"edge_idle",10'h155, 16'hFFF2, 1'b1, 16'h0000};
        vecs[5] = '{"miss_fff3",10'h001, 16'hFFF3, 1'b0, 16'h0000};
        vecs[6] = '{"sw_001",   10'h001, 16'hFFF0, 1'b1, 16'h0001};

        rst_n = 1'b0;
        I_SW = 10'h000;
        I_KEY = 4'b0000;
        I_ReadEnable = 1'b0;
        I_ReadAddr = 16'h0000;

        // Reset with all keys held down.
        cycles(4);
        chk("rst_valid", {31'd0, O_ReadValid}, 0);
        chk("rst_hit", {31'd0, O_ReadHit}, 0);
        chk("rst_data", {16'd0, O_ReadData}, 0);
        chk("rst_keyevent", {31'd0, O_KeyEvent}, 0);
        rst_n = 1'b1;
        rd("key_before_debounce", 16'hFFF1, 1'b1, 16'h0000);
        cycles(20);
        rd("key_all_pressed", 16'hFFF1, 1'b1, 16'h000F);
        chk("keyevent_all", {31'd0, O_KeyEvent}, 1);
        rd("edge_all", 16'hFFF2, 1'b1, 16'h000F);
        rd("edge_all_cleared", 16'hFFF2, 1'b1, 16'h0000);
        chk("keyevent_cleared", {31'd0, O_KeyEvent}, 0);
        I_KEY = 4'b1111;
        cycles(20);
        rd("key_released", 16'hFFF1, 1'b1, 16'h0000);

        // Vector table, one read per entry with settled switches.
        for (int i = 0; i < 7; i++) begin
            I_SW = vecs[i].sw;
            cycles(3);
            rd(vecs[i].name, vecs[i].addr, vecs[i].hit, vecs[i].data);
        end

        // Back-to-back burst over the same table with fixed switches.
        I_SW = 10'h2A5;
        cycles(3);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            I_ReadEnable = 1'b1;
            I_ReadAddr   = vecs[i].addr;
            sb_q.push_back('{{"burst_", vecs[i].name}, vecs[i].hit,
                             (vecs[i].addr == 16'hFFF0) ? 16'h02A5 : 16'h0000});
        end
        @(negedge clk);
        I_ReadEnable = 1'b0;
        drain_check("burst");

        // Hold behaviour: hit/data keep last values while idle.
        rd("hold_setup", 16'hFFF0, 1'b1, 16'h02A5);
        cycles(2);
        chk("hold_valid", {31'd0, O_ReadValid}, 0);
        chk("hold_hit", {31'd0, O_ReadHit}, 1);
        chk("hold_data", {16'd0, O_ReadData}, 16'h02A5);

        // Glitch shorter than the debounce window is rejected.
        @(negedge clk);
        I_KEY = 4'b1011;
        cycles(5);
        I_KEY = 4'b1111;
        cycles(20);
        rd("glitch_key", 16'hFFF1, 1'b1, 16'h0000);
        rd("glitch_edge", 16'hFFF2, 1'b1, 16'h0000);

        // Long press on KEY[2], then KEY[0].
        I_KEY = 4'b1011;
        cycles(20);
        rd("press_key2", 16'hFFF1, 1'b1, 16'h0004);
        chk("keyevent_key2", {31'd0, O_KeyEvent}, 1);
        I_KEY = 4'b1010;
        cycles(20);
        rd("rtc_edge_0101", 16'hFFF2, 1'b1, 16'h0005);
        rd("rtc_edge_after", 16'hFFF2, 1'b1, 16'h0000);
        chk("keyevent_after_rtc", {31'd0, O_KeyEvent}, 0);

        // Same-cycle set and clear: KEY[3] accepted on the read edge.
        I_KEY = 4'b1111;
        cycles(20);
        I_KEY = 4'b1110;
        cycles(20);
        I_KEY = 4'b0110;
        cycles(8);
        rd("simul_read", 16'hFFF2, 1'b1, 16'h0001);
        rd("simul_next", 16'hFFF2, 1'b1, 16'h0008);
        rd("simul_level", 16'hFFF1, 1'b1, 16'h0009);

        // Reset in the cycle after a request.
        I_KEY = 4'b1111;
        @(negedge clk);
        I_ReadEnable = 1'b1;
        I_ReadAddr   = 16'hFFF0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        I_ReadEnable = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, O_ReadValid}, 0);
        chk("midrst_hit", {31'd0, O_ReadHit}, 0);
        chk("midrst_data", {16'd0, O_ReadData}, 0);
        chk("midrst_keyevent", {31'd0, O_KeyEvent}, 0);
        cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_valid", {31'd0, O_ReadValid}, 0);
        end
        rd("postrst_miss", 16'h1234, 1'b0, 16'h0000);

        cycles(2);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
